elevator_button_debounce: RTL and testbench

// - Front-end conditioning stage feeding the elevator controller's seven request inputs.
// - Synchronises raw, asynchronous, bouncing push-button lines (hall up/down, car floor buttons).
// - Debounces each line and emits a clean debounced level plus a single-cycle press pulse per button.
// - Pulses drive button_pressed of the latching request buttons; stuck flags go to maintenance status.

---
 rtl/elevator_button_debounce_pkg.sv | 29 ++
 rtl/elevator_debounce_cell.sv | 138 +++++++++++++
 rtl/elevator_button_debounce.sv | 41 ++++
 tb/tb_elevator_button_debounce.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_button_debounce_pkg.sv
// Shared definitions for the elevator push-button conditioning stage.
// Holds the button count, the bit index of each physical button in the
// request vector, and the state encoding used by every debounce cell.
package elevator_button_debounce_pkg;

   localparam int NUM_BUTTONS = 7;

   // Bit positions of each button inside btn_raw / btn_level / btn_pulse / btn_stuck
   localparam int BTN_F1_UP   = 0;
   localparam int BTN_F2_DOWN = 1;
   localparam int BTN_F2_UP   = 2;
   localparam int BTN_F3_DOWN = 3;
   localparam int BTN_CAR_F1  = 4;
   localparam int BTN_CAR_F2  = 5;
   localparam int BTN_CAR_F3  = 6;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESS   = 2'd1,
      ST_HELD    = 2'd2,
      ST_RELEASE = 2'd3
   } cell_state_t;

   // The debounced level is high in exactly these two states
   function automatic logic is_high_state(input cell_state_t st);
      return (st == ST_HELD) || (st == ST_RELEASE);
   endfunction

endpackage

// File: rtl/elevator_debounce_cell.sv
// Conditioning for a single button line: synchroniser chain, 4-state debounce
// FSM with its stability counter, and a saturating stuck-button counter.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   btn_raw    - raw asynchronous button line (1 = pressed)
//   btn_level  - debounced level (registered)
//   btn_pulse  - one-cycle pulse on accepted press (registered)
//   btn_stuck  - line has been accepted-high for STUCK_CYCLES (registered)
module elevator_debounce_cell
   import elevator_button_debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int STUCK_CYCLES    = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_pulse,
   output logic btn_stuck
);

   localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int SCNT_W = $clog2(STUCK_CYCLES + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   cell_state_t            state_q, state_d;
   logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
   logic [SCNT_W-1:0]      scnt_q, scnt_d;
   logic                   level_d, pulse_d, stuck_d;

   assign s = sync_q[SYNC_STAGES-1];

   // Synchroniser chain; only its last stage is ever looked at by the FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         dcnt_q    <= '0;
         scnt_q    <= '0;
         btn_level <= 1'b0;
         btn_pulse <= 1'b0;
         btn_stuck <= 1'b0;
      end else begin
         state_q   <= state_d;
         dcnt_q    <= dcnt_d;
         scnt_q    <= scnt_d;
         btn_level <= level_d;
         btn_pulse <= pulse_d;
         btn_stuck <= stuck_d;
      end
   end

   // Next state: a change of the synchronised line must persist for
   // DEBOUNCE_CYCLES consecutive cycles; any reversion restarts from the
   // stable state. With DEBOUNCE_CYCLES==1 the intermediate states are skipped.
   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      case (state_q)
         ST_IDLE: begin
            dcnt_d = '0;
            if (s) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = ST_HELD;
               end else begin
                  state_d = ST_PRESS;
                  dcnt_d  = DCNT_W'(1);
               end
            end
         end
         ST_PRESS: begin
            if (!s) begin
               state_d = ST_IDLE;
               dcnt_d  = '0;
            end else if (dcnt_q >= DCNT_W'(DEBOUNCE_CYCLES - 1)) begin
               state_d = ST_HELD;
               dcnt_d  = '0;
            end else begin
               dcnt_d = dcnt_q + DCNT_W'(1);
            end
         end
         ST_HELD: begin
            dcnt_d = '0;
            if (!s) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_RELEASE;
                  dcnt_d  = DCNT_W'(1);
               end
            end
         end
         ST_RELEASE: begin
            if (s) begin
               state_d = ST_HELD;
               dcnt_d  = '0;
            end else if (dcnt_q >= DCNT_W'(DEBOUNCE_CYCLES - 1)) begin
               state_d = ST_IDLE;
               dcnt_d  = '0;
            end else begin
               dcnt_d = dcnt_q + DCNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            dcnt_d  = '0;
         end
      endcase
   end

   // Output decode. The pulse marks entry into the high states from a low one.
   // The stuck counter runs only across cycles that start and end high, so it
   // restarts on every accepted press and clears on accepted release.
   always_comb begin
      level_d = is_high_state(state_d);
      pulse_d = !is_high_state(state_q) && is_high_state(state_d);
      if (!is_high_state(state_q) || !is_high_state(state_d)) begin
         scnt_d = '0;
      end else if (scnt_q != SCNT_W'(STUCK_CYCLES)) begin
         scnt_d = scnt_q + SCNT_W'(1);
      end else begin
         scnt_d = scnt_q;
      end
      stuck_d = (scnt_d == SCNT_W'(STUCK_CYCLES));
   end

endmodule

// File: rtl/elevator_button_debounce.sv
// Front-end conditioning for the elevator controller's request buttons.
// One independent debounce cell per button line; outputs are concatenated
// so bit i of every output belongs to bit i of btn_raw.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   btn_raw    - raw asynchronous button lines (1 = pressed)
//   btn_level  - debounced level per button
//   btn_pulse  - one-cycle pulse per accepted press
//   btn_stuck  - per-button stuck (held too long) flag
module elevator_button_debounce
   import elevator_button_debounce_pkg::*;
#(
   parameter int NUM_BUTTONS     = elevator_button_debounce_pkg::NUM_BUTTONS,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int STUCK_CYCLES    = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_BUTTONS-1:0] btn_raw,
   output logic [NUM_BUTTONS-1:0] btn_level,
   output logic [NUM_BUTTONS-1:0] btn_pulse,
   output logic [NUM_BUTTONS-1:0] btn_stuck
);

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_cell
      elevator_debounce_cell #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .STUCK_CYCLES    (STUCK_CYCLES)
      ) u_cell (
         .clk       (clk),
         .rst       (rst),
         .btn_raw   (btn_raw[i]),
         .btn_level (btn_level[i]),
         .btn_pulse (btn_pulse[i]),
         .btn_stuck (btn_stuck[i])
      );
   end

endmodule

// File: tb/tb_elevator_button_debounce.sv
// Bench for elevator_button_debounce with short debounce/stuck windows.
// A run-length model predicts every output each cycle; directed scenarios
// add hand-computed literal expectations at known edges.
module tb_elevator_button_debounce;

   localparam int NB    = 7;
   localparam int SYNC  = 2;
   localparam int DEB   = 4;
   localparam int STUCK = 32;

   logic          clk;
   logic          rst;
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_pulse;
   logic [NB-1:0] btn_stuck;

   int checks;
   int errors;
   bit model_valid;
   int pulse_cnt [NB];

   elevator_button_debounce #(
      .NUM_BUTTONS     (NB),
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .STUCK_CYCLES    (STUCK)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .btn_pulse (btn_pulse),
      .btn_stuck (btn_stuck)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: the line seen by the debouncer is btn_raw delayed SYNC edges; the
   // level flips once the seen line has disagreed with it for DEB edges in a row.
   logic [NB-1:0] m_pipe [SYNC];
   int            m_run  [NB];
   int            m_scnt [NB];
   logic [NB-1:0] m_level, m_pulse, m_stuck;

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < SYNC; k++) m_pipe[k] <= '0;
         for (int i = 0; i < NB; i++) begin
            m_run[i]  <= 0;
            m_scnt[i] <= 0;
         end
         m_level <= '0;
         m_pulse <= '0;
         m_stuck <= '0;
      end else begin
         for (int k = SYNC - 1; k > 0; k--) m_pipe[k] <= m_pipe[k-1];
         m_pipe[0] <= btn_raw;
         for (int i = 0; i < NB; i++) begin
            logic seen;
            logic nl;
            int   run;
            int   sc;
            seen = m_pipe[SYNC-1][i];
            nl   = m_level[i];
            run  = (seen != m_level[i]) ? m_run[i] + 1 : 0;
            if (run == DEB) begin
               nl  = seen;
               run = 0;
            end
            if (!nl || !m_level[i]) sc = 0;
            else sc = (m_scnt[i] + 1 > STUCK) ? STUCK : m_scnt[i] + 1;
            m_run[i]   <= run;
            m_scnt[i]  <= sc;
            m_level[i] <= nl;
            m_pulse[i] <= nl & ~m_level[i];
            m_stuck[i] <= (sc == STUCK);
         end
      end
   end

   task automatic check_output(input string name, input logic [NB-1:0] actual,
                               input logic [NB-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (model_valid) begin
         check_output("model_level", btn_level, m_level);
         check_output("model_pulse", btn_pulse, m_pulse);
         check_output("model_stuck", btn_stuck, m_stuck);
      end
   end

   // Pulse tally per button, used for "exactly one pulse" checks
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NB; i++) if (btn_pulse[i] === 1'b1) pulse_cnt[i]++;
      end
   end

   task automatic apply_stimulus(input logic [NB-1:0] raw, input int cycles);
      @(negedge clk);
      btn_raw = raw;
      repeat (cycles) @(posedge clk);
   endtask

   task automatic edges_then_sample(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int base;

   initial begin
      checks      = 0;
      errors      = 0;
      model_valid = 1'b0;
      for (int i = 0; i < NB; i++) pulse_cnt[i] = 0;
      rst     = 1'b1;
      btn_raw = '0;
      repeat (3) @(posedge clk);
      #1;
      model_valid = 1'b1;
      check_output("reset_level", btn_level, '0);
      check_output("reset_pulse", btn_pulse, '0);
      check_output("reset_stuck", btn_stuck, '0);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] clean press on bit 0");
      @(negedge clk);
      btn_raw = 7'b0000001;
      edges_then_sample(5);
      check_output("press_edge5_level", btn_level, 7'b0000000);
      edges_then_sample(1);
      check_output("press_edge6_level", btn_level, 7'b0000001);
      check_output("press_edge6_pulse", btn_pulse, 7'b0000001);
      edges_then_sample(1);
      check_output("press_edge7_pulse", btn_pulse, 7'b0000000);
      check_output("press_edge7_level", btn_level, 7'b0000001);
      repeat (13) @(posedge clk);
      apply_stimulus(7'b0000000, 10);

      $display("[TB] bounce rejection on bit 3");
      base = pulse_cnt[3];
      apply_stimulus(7'b0001000, 1);
      apply_stimulus(7'b0000000, 1);
      apply_stimulus(7'b0001000, 1);
      apply_stimulus(7'b0000000, 1);
      apply_stimulus(7'b0001000, 1);
      apply_stimulus(7'b0000000, 10);
      #1;
      check_output("bounce_level", btn_level, 7'b0000000);
      check_output("bounce_no_pulse", 7'(pulse_cnt[3] - base), 7'd0);
      apply_stimulus(7'b0001000, 6);
      apply_stimulus(7'b0000000, 10);
      #1;
      check_output("bounce_then_one_pulse", 7'(pulse_cnt[3] - base), 7'd1);

      $display("[TB] release bounce on bit 5");
      base = pulse_cnt[5];
      apply_stimulus(7'b0100000, 10);
      apply_stimulus(7'b0000000, 2);
      apply_stimulus(7'b0100000, 6);
      #1;
      check_output("relbounce_level", btn_level, 7'b0100000);
      check_output("relbounce_one_pulse", 7'(pulse_cnt[5] - base), 7'd1);
      @(negedge clk);
      btn_raw = 7'b0000000;
      edges_then_sample(5);
      check_output("release_edge5_level", btn_level, 7'b0100000);
      edges_then_sample(1);
      check_output("release_edge6_level", btn_level, 7'b0000000);
      repeat (4) @(posedge clk);

      $display("[TB] simultaneous presses");
      @(negedge clk);
      btn_raw = 7'b1010101;
      edges_then_sample(6);
      check_output("simul_pulse", btn_pulse, 7'b1010101);
      check_output("simul_level", btn_level, 7'b1010101);
      apply_stimulus(7'b0000000, 10);

      $display("[TB] stuck detection on bit 6");
      @(negedge clk);
      btn_raw = 7'b1000000;
      edges_then_sample(6);
      check_output("stuck_rise_level", btn_level, 7'b1000000);
      edges_then_sample(31);
      check_output("stuck_edge31", btn_stuck, 7'b0000000);
      edges_then_sample(1);
      check_output("stuck_edge32", btn_stuck, 7'b1000000);
      edges_then_sample(12);
      check_output("stuck_holds", btn_stuck, 7'b1000000);
      @(negedge clk);
      btn_raw = 7'b0000000;
      edges_then_sample(5);
      check_output("stuck_before_release", btn_stuck, 7'b1000000);
      edges_then_sample(1);
      check_output("stuck_cleared", btn_stuck, 7'b0000000);
      check_output("stuck_level_fall", btn_level, 7'b0000000);
      repeat (4) @(posedge clk);

      $display("[TB] reset while bit 2 held");
      apply_stimulus(7'b0000100, 10);
      #1;
      check_output("prereset_level", btn_level, 7'b0000100);
      @(negedge clk);
      rst = 1'b1;
      edges_then_sample(1);
      check_output("midreset_level", btn_level, 7'b0000000);
      check_output("midreset_pulse", btn_pulse, 7'b0000000);
      check_output("midreset_stuck", btn_stuck, 7'b0000000);
      @(negedge clk);
      rst = 1'b0;
      edges_then_sample(5);
      check_output("postreset_edge5_pulse", btn_pulse, 7'b0000000);
      edges_then_sample(1);
      check_output("postreset_edge6_pulse", btn_pulse, 7'b0000100);
      apply_stimulus(7'b0000000, 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
